// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing engine: pixel-tick divider, h/v counters, frame-latched
// pattern select and a one-tick registered sync/RGB output stage.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOT),
    localparam int VW      = $clog2(V_TOT)
) (
    input  logic           clk_100m,
    input  logic           rst,
    input  logic [1:0]     mode,
    input  logic [R_W-1:0] pix_r,
    input  logic [G_W-1:0] pix_g,
    input  logic [B_W-1:0] pix_b,
    output logic [HW-1:0]  pix_x,
    output logic [VW-1:0]  pix_y,
    output logic           pix_req,
    output logic           pix_tick,
    output logic           frame_start,
    output logic           vga_hsync,
    output logic           vga_vsync,
    output logic [R_W-1:0] vga_r,
    output logic [G_W-1:0] vga_g,
    output logic [B_W-1:0] vga_b
);

    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int RGB_W = R_W + G_W + B_W;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_END      = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_L    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_ACT = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_END      = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_L    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON      = (HS_POL != 0);
    localparam logic          VS_ON      = (VS_POL != 0);

    // Constant-width compare chain, so no runtime divider is inferred.
    function automatic logic [2:0] bar_index(input logic [HW-1:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(h) >= k * BAR_W) idx = 3'(k);
        end
        return idx;
    endfunction

    function automatic logic [RGB_W-1:0] pattern_rgb(input logic [1:0]       m,
                                                     input logic [HW-1:0]    h,
                                                     input logic [VW-1:0]    v,
                                                     input logic [RGB_W-1:0] ext);
        logic [2:0]     bar;
        logic           on_border;
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        bar       = bar_index(h);
        on_border = (h == '0) || (h == H_LAST_ACT) || (v == '0) || (v == V_LAST_ACT);
        r = '0;
        g = '0;
        b = '0;
        case (m)
            2'd0: {r, g, b} = ext;
            2'd1: begin
                r = {R_W{bar[2]}};
                g = {G_W{bar[1]}};
                b = {B_W{bar[0]}};
            end
            // Bit 5 of each counter taken via 32-bit ints so narrow counters stay legal.
            2'd2: begin
                if (((int'(h) ^ int'(v)) & 32) != 0) begin
                    r = '1;
                    g = '1;
                    b = '1;
                end
            end
            default: begin
                b = '1;
                if (on_border) begin
                    r = '1;
                    g = '1;
                end
            end
        endcase
        return {r, g, b};
    endfunction

    logic [DW-1:0]    div_q;
    logic [HW-1:0]    h_p0;
    logic [VW-1:0]    v_p0;
    logic [1:0]       mode_q;
    logic [1:0]       mode_eff;
    logic             vld_p0;
    logic             h_wrap;
    logic             v_wrap;
    logic             active_p0;
    logic             fs_p0;
    logic             hs_p0;
    logic             vs_p0;
    logic [RGB_W-1:0] rgb_p0;
    logic             hsync_p1;
    logic             vsync_p1;
    logic [RGB_W-1:0] rgb_p1;

    // Stage p0: counters and combinational pixel decode
    always_comb begin
        vld_p0    = rst && (div_q == DIV_LAST);
        h_wrap    = (h_p0 == H_END);
        v_wrap    = (v_p0 == V_END);
        active_p0 = (h_p0 < H_ACT_L) && (v_p0 < V_ACT_L);
        fs_p0     = vld_p0 && (h_p0 == '0) && (v_p0 == '0);
        // The first pixel of a frame already uses the mode being latched on that tick.
        mode_eff  = fs_p0 ? mode : mode_q;
        hs_p0     = (h_p0 >= HS_BEG) && (h_p0 <= HS_END);
        vs_p0     = (v_p0 >= VS_BEG) && (v_p0 <= VS_END);
        rgb_p0    = active_p0 ? pattern_rgb(mode_eff, h_p0, v_p0, {pix_r, pix_g, pix_b}) : '0;
    end

    always_ff @(posedge clk_100m) begin
        if (!rst) begin
            div_q  <= '0;
            h_p0   <= '0;
            v_p0   <= '0;
            mode_q <= 2'd0;
        end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            if (vld_p0) begin
                if (fs_p0) mode_q <= mode;
                if (h_wrap) begin
                    h_p0 <= '0;
                    v_p0 <= v_wrap ? '0 : v_p0 + VW'(1);
                end else begin
                    h_p0 <= h_p0 + HW'(1);
                end
            end
        end
    end

    // Stage p1: registered sync and colour, one tick behind the counters
    always_ff @(posedge clk_100m) begin
        if (!rst) begin
            hsync_p1 <= !HS_ON;
            vsync_p1 <= !VS_ON;
            rgb_p1   <= '0;
        end else if (vld_p0) begin
            hsync_p1 <= hs_p0 ? HS_ON : !HS_ON;
            vsync_p1 <= vs_p0 ? VS_ON : !VS_ON;
            rgb_p1   <= rgb_p0;
        end
    end

    assign pix_x       = h_p0;
    assign pix_y       = v_p0;
    assign pix_tick    = vld_p0;
    assign pix_req     = vld_p0 && active_p0;
    assign frame_start = fs_p0;
    assign vga_hsync   = hsync_p1;
    assign vga_vsync   = vsync_p1;
    assign vga_r       = rgb_p1[RGB_W-1 -: R_W];
    assign vga_g       = rgb_p1[B_W +: G_W];
    assign vga_b       = rgb_p1[B_W-1:0];

endmodule
